// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the 5-stage MIPS pipeline.
//   DATA_W / REG_W  : datapath and register-index widths
//   ALUOP_*         : ALU-op class codes produced by the main control unit
//   mem_width_e     : load/store access width codes
//   id_ex_ctrl_t    : control field group carried by the ID/EX latch
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
  localparam logic [3:0] ALUOP_LDST  = 4'b0001;
  localparam logic [3:0] ALUOP_ADDI  = 4'b1000;
  localparam logic [3:0] ALUOP_SLTI  = 4'b1010;
  localparam logic [3:0] ALUOP_ANDI  = 4'b1100;
  localparam logic [3:0] ALUOP_ORI   = 4'b1101;
  localparam logic [3:0] ALUOP_XORI  = 4'b1110;
  localparam logic [3:0] ALUOP_LUI   = 4'b1111;

  typedef enum logic [1:0] {
    MW_BYTE = 2'd0,
    MW_HALF = 2'd1,
    MW_WORD = 2'd3
  } mem_width_e;

  // Everything that must read as "no-op" in a bubble lives in this group.
  typedef struct packed {
    logic       valid;
    logic [3:0] alu_op;
    logic [5:0] func;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_width;
    logic       mem_unsigned;
  } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline register with enable and synchronous clear.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset (highest priority)
//   i_en    : 0 holds the current value (clear is ignored while held)
//   i_clr   : with i_en=1, loads zero instead of i_d
//   i_d     : next value
//   o_q     : registered value
module pipe_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (i_en) begin
      q_d = i_clr ? '0 : i_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register of the 5-stage MIPS core.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_enable              : debug run/step enable; 0 freezes every field
//   i_flush, i_bubble     : either one (with i_enable=1) turns the slot into a bubble
//   i_valid / o_valid     : slot holds a real instruction
//   i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext : DATA_W data fields
//   i_rs, i_rt, i_rd, i_shamt                   : REG_W index fields
//   i_func, i_ALUop, control bits, i_mem_width, i_mem_unsigned : control fields
//   o_*                   : registered copy of the matching i_* (1-cycle latency)
module id_ex_latch #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_W  = mips_pkg::REG_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_pc_plus4,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [DATA_W-1:0] i_imm_ext,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [REG_W-1:0]  i_shamt,
  input  logic [5:0]        i_func,
  input  logic [3:0]        i_ALUop,
  input  logic              i_reg_dst,
  input  logic              i_alu_src,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  input  logic [1:0]        i_mem_width,
  input  logic              i_mem_unsigned,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [REG_W-1:0]  o_rs,
  output logic [REG_W-1:0]  o_rt,
  output logic [REG_W-1:0]  o_rd,
  output logic [REG_W-1:0]  o_shamt,
  output logic [5:0]        o_func,
  output logic [3:0]        o_ALUop,
  output logic              o_reg_dst,
  output logic              o_alu_src,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg,
  output logic              o_reg_write,
  output logic [1:0]        o_mem_width,
  output logic              o_mem_unsigned
);

  import mips_pkg::*;

  localparam int unsigned CTRL_W = $bits(id_ex_ctrl_t);
  localparam int unsigned IDX_W  = 4 * REG_W;
  localparam int unsigned DAT_W  = 4 * DATA_W;

  // Flush and bubble collapse into one clear; freeze is handled by i_en.
  logic clear;
  assign clear = i_flush | i_bubble;

  id_ex_ctrl_t        ctrl_d;
  id_ex_ctrl_t        ctrl_q;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   idx_q;
  logic [DAT_W-1:0]   dat_d;
  logic [DAT_W-1:0]   dat_q;

  always_comb begin
    ctrl_d              = '0;
    ctrl_d.valid        = i_valid;
    ctrl_d.alu_op       = i_ALUop;
    ctrl_d.func         = i_func;
    ctrl_d.reg_dst      = i_reg_dst;
    ctrl_d.alu_src      = i_alu_src;
    ctrl_d.mem_read     = i_mem_read;
    ctrl_d.mem_write    = i_mem_write;
    ctrl_d.mem_to_reg   = i_mem_to_reg;
    ctrl_d.reg_write    = i_reg_write;
    ctrl_d.mem_width    = i_mem_width;
    ctrl_d.mem_unsigned = i_mem_unsigned;
  end

  assign idx_d = {i_rs, i_rt, i_rd, i_shamt};
  assign dat_d = {i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_enable),
    .i_clr   (clear),
    .i_d     (ctrl_d),
    .o_q     (ctrl_q)
  );

  // Indices are cleared too so a bubble can never match in the forwarding unit.
  pipe_field_reg #(.W(IDX_W)) u_idx_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_enable),
    .i_clr   (clear),
    .i_d     (idx_d),
    .o_q     (idx_q)
  );

  pipe_field_reg #(.W(DAT_W)) u_dat_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_enable),
    .i_clr   (clear),
    .i_d     (dat_d),
    .o_q     (dat_q)
  );

  assign o_valid        = ctrl_q.valid;
  assign o_ALUop        = ctrl_q.alu_op;
  assign o_func         = ctrl_q.func;
  assign o_reg_dst      = ctrl_q.reg_dst;
  assign o_alu_src      = ctrl_q.alu_src;
  assign o_mem_read     = ctrl_q.mem_read;
  assign o_mem_write    = ctrl_q.mem_write;
  assign o_mem_to_reg   = ctrl_q.mem_to_reg;
  assign o_reg_write    = ctrl_q.reg_write;
  assign o_mem_width    = ctrl_q.mem_width;
  assign o_mem_unsigned = ctrl_q.mem_unsigned;

  assign {o_rs, o_rt, o_rd, o_shamt}                  = idx_q;
  assign {o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext} = dat_q;

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_flush, i_bubble, i_valid;
  logic [31:0] i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext;
  logic [4:0]  i_rs, i_rt, i_rd, i_shamt;
  logic [5:0]  i_func;
  logic [3:0]  i_ALUop;
  logic        i_reg_dst, i_alu_src, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write;
  logic [1:0]  i_mem_width;
  logic        i_mem_unsigned;

  logic        o_valid;
  logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_func;
  logic [3:0]  o_ALUop;
  logic        o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic [1:0]  o_mem_width;
  logic        o_mem_unsigned;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_latch #(.DATA_W(32), .REG_W(5)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_bubble(i_bubble), .i_valid(i_valid), .i_pc_plus4(i_pc_plus4),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm_ext(i_imm_ext),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .i_func(i_func),
    .i_ALUop(i_ALUop), .i_reg_dst(i_reg_dst), .i_alu_src(i_alu_src),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_mem_width(i_mem_width), .i_mem_unsigned(i_mem_unsigned),
    .o_valid(o_valid), .o_pc_plus4(o_pc_plus4), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt),
    .o_rd(o_rd), .o_shamt(o_shamt), .o_func(o_func), .o_ALUop(o_ALUop),
    .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_mem_width(o_mem_width), .o_mem_unsigned(o_mem_unsigned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    {i_valid, i_reg_dst, i_alu_src, i_mem_read, i_mem_write, i_mem_to_reg,
     i_reg_write, i_mem_unsigned} = {8{v}};
    i_pc_plus4 = {32{v}}; i_rs_data = {32{v}}; i_rt_data = {32{v}}; i_imm_ext = {32{v}};
    i_rs = {5{v}}; i_rt = {5{v}}; i_rd = {5{v}}; i_shamt = {5{v}};
    i_func = {6{v}}; i_ALUop = {4{v}}; i_mem_width = {2{v}};
  endtask

  initial begin
    // 1. Reset with every input high
    set_all(1'b1);
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b1; i_bubble = 1'b1;
    step();
    step();
    check("rst_valid",     o_valid,     32'd0);
    check("rst_aluop",     o_ALUop,     32'd0);
    check("rst_reg_write", o_reg_write, 32'd0);
    check("rst_mem_write", o_mem_write, 32'd0);
    check("rst_pc4",       o_pc_plus4,  32'd0);
    check("rst_rs_data",   o_rs_data,   32'd0);
    check("rst_rd",        o_rd,        32'd0);
    check("rst_func",      o_func,      32'd0);
    check("rst_mem_width", o_mem_width, 32'd0);

    // 2. Load ADD r5 = r3 + r4
    i_reset = 1'b0; i_flush = 1'b0; i_bubble = 1'b0;
    set_all(1'b0);
    i_valid = 1'b1; i_ALUop = 4'b0000; i_func = 6'b100000;
    i_rs = 5'd3; i_rt = 5'd4; i_rd = 5'd5; i_reg_write = 1'b1; i_reg_dst = 1'b1;
    i_rs_data = 32'h0000_0010; i_rt_data = 32'h0000_0022; i_pc_plus4 = 32'h0040_0004;
    step();
    check("add_valid",     o_valid,     32'd1);
    check("add_func",      o_func,      32'h20);
    check("add_rs",        o_rs,        32'd3);
    check("add_rt",        o_rt,        32'd4);
    check("add_rd",        o_rd,        32'd5);
    check("add_reg_write", o_reg_write, 32'd1);
    check("add_rs_data",   o_rs_data,   32'h10);
    check("add_pc4",       o_pc_plus4,  32'h0040_0004);
    // inputs change mid-cycle: outputs must not follow before the edge
    i_rd = 5'd6; i_reg_write = 1'b0; i_rs_data = 32'hDEAD_BEEF;
    #3;
    check("add_hold_rd",   o_rd,        32'd5);
    check("add_hold_rsd",  o_rs_data,   32'h10);
    step();
    check("add_next_rd",   o_rd,        32'd6);
    check("add_next_rsd",  o_rs_data,   32'hDEAD_BEEF);

    // 3. LW then one-cycle bubble
    set_all(1'b0);
    i_valid = 1'b1; i_ALUop = 4'b0001; i_mem_read = 1'b1; i_mem_to_reg = 1'b1;
    i_reg_write = 1'b1; i_alu_src = 1'b1; i_mem_width = 2'd3; i_rs = 5'd7; i_rt = 5'd8;
    i_imm_ext = 32'h0000_0004;
    step();
    check("lw_mem_read",   o_mem_read,  32'd1);
    check("lw_mem_width",  o_mem_width, 32'd3);
    i_bubble = 1'b1;
    step();
    check("bub_mem_read",  o_mem_read,  32'd0);
    check("bub_reg_write", o_reg_write, 32'd0);
    check("bub_rs",        o_rs,        32'd0);
    check("bub_valid",     o_valid,     32'd0);
    check("bub_imm",       o_imm_ext,   32'd0);
    check("bub_aluop",     o_ALUop,     32'd0);
    check("bub_mem_width", o_mem_width, 32'd0);
    i_bubble = 1'b0;
    step();
    check("post_bub_mr",   o_mem_read,  32'd1);
    check("post_bub_rs",   o_rs,        32'd7);
    check("post_bub_val",  o_valid,     32'd1);

    // 4. Freeze beats flush
    i_enable = 1'b0; i_flush = 1'b1;
    i_ALUop = 4'b1100; i_rs = 5'd9; i_rs_data = 32'h1234_5678; i_mem_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_aluop",   o_ALUop,     32'd1);
      check("frz_rs",      o_rs,        32'd7);
      check("frz_valid",   o_valid,     32'd1);
    end
    i_enable = 1'b1;
    step();
    check("fl_valid",      o_valid,     32'd0);
    check("fl_rs",         o_rs,        32'd0);
    check("fl_rs_data",    o_rs_data,   32'd0);
    check("fl_aluop",      o_ALUop,     32'd0);
    // flush and bubble together act as a single clear
    i_flush = 1'b0;
    i_ALUop = 4'b1000; i_rt = 5'd11; i_reg_write = 1'b1;
    step();
    check("addi_aluop",    o_ALUop,     32'd8);
    check("addi_rt",       o_rt,        32'd11);
    i_flush = 1'b1; i_bubble = 1'b1;
    step();
    check("fb_valid",      o_valid,     32'd0);
    check("fb_rt",         o_rt,        32'd0);
    check("fb_reg_write",  o_reg_write, 32'd0);
    i_flush = 1'b0; i_bubble = 1'b0;

    // 5. Step mode: enable 1-0-0-1
    set_all(1'b0);
    i_valid = 1'b1; i_ALUop = 4'b1101; i_alu_src = 1'b1; i_reg_write = 1'b1;
    i_imm_ext = 32'h0000_00FF;
    i_enable = 1'b1;
    step();
    check("stp0_aluop",    o_ALUop,     32'hD);
    i_enable = 1'b0; i_ALUop = 4'b1111; i_imm_ext = 32'h0000_ABCD;
    step();
    check("stp1_aluop",    o_ALUop,     32'hD);
    step();
    check("stp2_aluop",    o_ALUop,     32'hD);
    check("stp2_imm",      o_imm_ext,   32'hFF);
    i_enable = 1'b1;
    step();
    check("stp3_aluop",    o_ALUop,     32'hF);
    check("stp3_imm",      o_imm_ext,   32'h0000_ABCD);

    // 6. Reset in the same cycle as a load
    i_reg_write = 1'b1; i_valid = 1'b1; i_rd = 5'd12; i_reset = 1'b1;
    step();
    check("mrst_reg_write", o_reg_write, 32'd0);
    check("mrst_valid",     o_valid,     32'd0);
    check("mrst_rd",        o_rd,        32'd0);
    check("mrst_imm",       o_imm_ext,   32'd0);
    i_reset = 1'b0;
    step();
    check("mrst_after_rd",  o_rd,        32'd12);
    check("mrst_after_val", o_valid,     32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
